syscall_string_reader: RTL and testbench
========================================

SYSCALL_STRING_READER -- requirements
Module: syscall_string_reader

Interface
REQ-001 SHALL have parameter MAX_LEN, default 256, giving the maximum number of characters emitted per request.
REQ-002 SHALL have parameter CNT_W, default 9, giving the char_count width; it SHALL satisfy 2^CNT_W > MAX_LEN.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request pulse from the syscall decode, sampled only in IDLE.
REQ-006 SHALL have port str_addr  input  32  byte address of the NUL-terminated string, sampled with start.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port truncated  output  1  set when MAX_LEN was reached before NUL; held until next accepted start.
REQ-010 SHALL have port char_count  output  CNT_W  number of characters accepted in the current or last request.
REQ-011 SHALL have port mem_read  output  1  read strobe to data memory.
REQ-012 SHALL have port mem_address  output  32  word-aligned data memory address.
REQ-013 SHALL have port mem_read_data  input  32  data memory word; combinational, valid in the same cycle as mem_read.
REQ-014 SHALL have port char_valid  output  1  char_data is valid.
REQ-015 SHALL have port char_data  output  8  character byte.
REQ-016 SHALL have port char_ready  input  1  consumer accepts; transfer occurs when char_valid and char_ready are both high at a rising edge.

Function
REQ-017 SHALL implement states IDLE, FETCH, EMIT and DONE.
REQ-018 IDLE: on start, SHALL load ptr=str_addr, clear char_count and truncated, and go to FETCH; start SHALL be ignored in all other states.
REQ-019 FETCH: SHALL assert mem_read with mem_address={ptr[31:2],2'b00}, capture mem_read_data into word_reg, and go to EMIT; mem_read SHALL be 0 in all other states.
REQ-020 EMIT: SHALL select a byte of word_reg, little-endian: ptr[1:0]=0 selects bits 7:0, 1 selects 15:8, 2 selects 23:16, 3 selects 31:24.
REQ-021 EMIT: if the selected byte is 0x00, SHALL go to DONE without asserting char_valid.
REQ-022 EMIT: for a nonzero byte, SHALL assert char_valid with char_data equal to that byte.
REQ-023 EMIT: char_valid and char_data SHALL remain stable while char_ready is low, and no memory access SHALL occur while stalled.
REQ-024 EMIT: on each transfer SHALL increment char_count and ptr, with ptr wrapping modulo 2^32.
REQ-025 After a transfer in EMIT, the next state SHALL be chosen in priority order: DONE with truncated=1 if char_count reaches MAX_LEN; else FETCH if the old ptr[1:0]=3; else EMIT.
REQ-026 DONE: SHALL assert done for exactly one cycle and then go to IDLE.
REQ-027 Latency: with start sampled at edge k, FETCH SHALL occupy cycle k+1 and the first char_valid (or the NUL detection) SHALL occur in cycle k+2.
REQ-028 Each string word SHALL be fetched exactly once per request.

Reset
REQ-029 On reset: state=IDLE, ptr=0, word_reg=0, char_count=0, and busy, done, truncated, mem_read, mem_address, char_valid, char_data all 0.
REQ-030 Reset asserted mid-operation SHALL abort the request with no further char_valid or done.

Structure
REQ-031 A shared package SHALL define the state enum, the NUL constant 8'h00, and BYTE_W=8.
REQ-032 Byte selection SHALL be a sub-module byte_lane_select (inputs: word, lane[1:0]; output: byte), purely combinational.

Verification
REQ-033 "Hello" test: mem[0x10010000]=0x6C6C6548, mem[0x10010004]=0x0000006F, start at 0x10010000 with char_ready=1 -> chars 48,65,6C,6C,6F; char_count=5; two fetches; done pulse; truncated=0.
REQ-034 Unaligned start: same memory, str_addr=0x10010002 -> chars 6C,6C,6F; char_count=3.
REQ-035 Empty string: mem[0x10010000]=0x00000000, start at edge k -> no char_valid; done high in cycle k+3.
REQ-036 Backpressure: char_ready held low 3 cycles on the first char -> char_data=48 held stable; mem_read stays 0; the sequence is otherwise unchanged.
REQ-037 Truncation: MAX_LEN=4 and 8 nonzero bytes -> exactly 4 chars; truncated=1; char_count=4.
REQ-038 Reset and start gating: reset asserted in EMIT -> next cycle busy=0, char_valid=0, and no done; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/syscall_string_reader_pkg.sv
// Shared types and constants for the syscall string reader.
package syscall_string_reader_pkg;

   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] NUL = 8'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/syscall_string_reader_if.sv
// Request, data-memory and character-stream signals of the string reader.
interface syscall_string_reader_if #(
   parameter int CNT_W = 9
);
   import syscall_string_reader_pkg::*;

   logic              start;
   logic [31:0]       str_addr;
   logic              busy;
   logic              done;
   logic              truncated;
   logic [CNT_W-1:0]  char_count;
   logic              mem_read;
   logic [31:0]       mem_address;
   logic [31:0]       mem_read_data;
   logic              char_valid;
   logic [BYTE_W-1:0] char_data;
   logic              char_ready;

   // Requester / memory / consumer side.
   modport master (
      output start, str_addr, mem_read_data, char_ready,
      input  busy, done, truncated, char_count, mem_read, mem_address,
             char_valid, char_data
   );

   // Reader side.
   modport slave (
      input  start, str_addr, mem_read_data, char_ready,
      output busy, done, truncated, char_count, mem_read, mem_address,
             char_valid, char_data
   );

endinterface

// File: rtl/syscall_string_reader_byte_lane_select.sv
// Little-endian byte lane picker for a 32-bit word.
module byte_lane_select
   import syscall_string_reader_pkg::*;
(
   input  logic [31:0]       word,
   input  logic [1:0]        lane,
   output logic [BYTE_W-1:0] lane_byte
);

   // Lane 0 is the least significant byte.
   always_comb begin
      unique case (lane)
         2'd0:    lane_byte = word[7:0];
         2'd1:    lane_byte = word[15:8];
         2'd2:    lane_byte = word[23:16];
         default: lane_byte = word[31:24];
      endcase
   end

endmodule

// File: rtl/syscall_string_reader.sv
// Reads a NUL-terminated string from word-wide data memory and streams it
// out one character at a time over a valid/ready handshake.
// CNT_W must satisfy 2**CNT_W > MAX_LEN so the final count is representable.
module syscall_string_reader
   import syscall_string_reader_pkg::*;
#(
   parameter int MAX_LEN = 256,
   parameter int CNT_W   = 9
) (
   input logic                  clk,
   input logic                  reset,
   syscall_string_reader_if.slave bus
);

   state_t            state, state_nxt;
   logic [31:0]       ptr;
   logic [31:0]       word_reg;
   logic [CNT_W-1:0]  char_count;
   logic              truncated;
   logic [BYTE_W-1:0] cur_byte;
   logic [CNT_W-1:0]  count_inc;
   logic              is_nul;
   logic              transfer;
   logic              hit_max;

   byte_lane_select u_lane (
      .word      (word_reg),
      .lane      (ptr[1:0]),
      .lane_byte (cur_byte)
   );

   assign is_nul    = (cur_byte == NUL);
   assign transfer  = (state == EMIT) && !is_nul && bus.char_ready;
   assign count_inc = char_count + 1'b1;
   assign hit_max   = (count_inc == CNT_W'(MAX_LEN));

   // State register; reset drops any request in flight.
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignment so every flop samples
      // pre-edge values regardless of process ordering.
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state selection and Moore/handshake outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_nxt       = state;
      bus.busy        = 1'b1;
      bus.done        = 1'b0;
      bus.mem_read    = 1'b0;
      bus.mem_address = 32'h0;
      bus.char_valid  = 1'b0;
      bus.char_data   = NUL;
      unique case (state)
         IDLE: begin
            bus.busy = 1'b0;
            if (bus.start) state_nxt = FETCH;
         end
         FETCH: begin
            bus.mem_read    = 1'b1;
            bus.mem_address = {ptr[31:2], 2'b00};
            state_nxt       = EMIT;
         end
         EMIT: begin
            if (is_nul) begin
               state_nxt = DONE;
            end else begin
               bus.char_valid = 1'b1;
               bus.char_data  = cur_byte;
               if (bus.char_ready) begin
                  if (hit_max)              state_nxt = DONE;
                  else if (ptr[1:0] == 2'd3) state_nxt = FETCH;
                  else                      state_nxt = EMIT;
               end
            end
         end
         default: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // Pointer, fetched word, count and truncation flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr        <= 32'h0;
         word_reg   <= 32'h0;
         char_count <= '0;
         truncated  <= 1'b0;
      end else begin
         if (state == IDLE && bus.start) begin
            ptr        <= bus.str_addr;
            char_count <= '0;
            truncated  <= 1'b0;
         end
         if (state == FETCH) word_reg <= bus.mem_read_data;
         if (transfer) begin
            ptr        <= ptr + 32'd1;
            char_count <= count_inc;
            if (hit_max) truncated <= 1'b1;
         end
      end
   end

   assign bus.truncated  = truncated;
   assign bus.char_count = char_count;

endmodule

// File: tb/tb_syscall_string_reader.sv
// Directed bench for syscall_string_reader: default instance plus a
// MAX_LEN=4 instance for truncation.
module tb_syscall_string_reader;

   localparam logic [31:0] BASE = 32'h1001_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   syscall_string_reader_if #(.CNT_W(9)) bus ();
   syscall_string_reader_if #(.CNT_W(3)) bus4 ();

   syscall_string_reader #(.MAX_LEN(256), .CNT_W(9)) dut (
      .clk (clk), .reset (reset), .bus (bus.slave)
   );
   syscall_string_reader #(.MAX_LEN(4), .CNT_W(3)) dut4 (
      .clk (clk), .reset (reset), .bus (bus4.slave)
   );

   logic [31:0] mem_words  [0:7];
   logic [31:0] mem4_words [0:7];

   // Combinational memories covering BASE .. BASE+31.
   always_comb begin
      if (bus.mem_address[31:5] == BASE[31:5]) bus.mem_read_data = mem_words[bus.mem_address[4:2]];
      else                                     bus.mem_read_data = 32'hDEAD_BEEF;
      if (bus4.mem_address[31:5] == BASE[31:5]) bus4.mem_read_data = mem4_words[bus4.mem_address[4:2]];
      else                                      bus4.mem_read_data = 32'hDEAD_BEEF;
   end

   logic [7:0] q8[$];
   logic [7:0] q4[$];
   int fetch_cnt, fetch4_cnt, done_cnt, done4_cnt;

   // Record transfers, fetches and done pulses at the active edge.
   always @(posedge clk) begin
      if (bus.char_valid && bus.char_ready) q8.push_back(bus.char_data);
      if (bus4.char_valid && bus4.char_ready) q4.push_back(bus4.char_data);
      if (bus.mem_read) fetch_cnt++;
      if (bus4.mem_read) fetch4_cnt++;
      if (bus.done) done_cnt++;
      if (bus4.done) done4_cnt++;
   end

   int total = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_chars(input string tag, input logic [7:0] got[$],
                              input int n, input logic [63:0] exp);
      check({tag, "_len"}, got.size(), n);
      for (int i = 0; i < n; i++)
         check($sformatf("%s_c%0d", tag, i),
               (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF, {24'h0, exp[8*i +: 8]});
   endtask

   task automatic clear_mon();
      q8.delete(); q4.delete();
      fetch_cnt = 0; fetch4_cnt = 0; done_cnt = 0; done4_cnt = 0;
   endtask

   // Pulse start for one edge; returns at the negedge of the FETCH cycle.
   task automatic do_start(input logic [31:0] addr);
      bus.start = 1'b1; bus.str_addr = addr;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic do_start4(input logic [31:0] addr);
      bus4.start = 1'b1; bus4.str_addr = addr;
      @(negedge clk);
      bus4.start = 1'b0;
   endtask

   // Bounded wait for done; returns one cycle after the done pulse.
   task automatic wait_done(input string tag, input bit use4);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (use4 ? bus4.done : bus.done) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      bus.start = 1'b0; bus.str_addr = 32'h0; bus.char_ready = 1'b1;
      bus4.start = 1'b0; bus4.str_addr = 32'h0; bus4.char_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin mem_words[i] = 32'h0; mem4_words[i] = 32'h0; end
      mem_words[0]  = 32'h6C6C_6548;
      mem_words[1]  = 32'h0000_006F;
      mem4_words[0] = 32'h4443_4241;
      mem4_words[1] = 32'h4847_4645;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_trunc", bus.truncated, 0);
      check("rst_count", bus.char_count, 0);
      check("rst_mem_read", bus.mem_read, 0);
      check("rst_mem_addr", bus.mem_address, 0);
      check("rst_valid", bus.char_valid, 0);
      check("rst_data", bus.char_data, 0);
      reset = 1'b0;
      @(negedge clk);

      // Hello, aligned, with latency
      clear_mon();
      do_start(BASE);
      check("hello_fetch_rd", bus.mem_read, 1);
      check("hello_fetch_addr", bus.mem_address, BASE);
      check("hello_fetch_busy", bus.busy, 1);
      @(negedge clk);
      check("hello_first_valid", bus.char_valid, 1);
      check("hello_first_data", bus.char_data, 32'h48);
      wait_done("hello", 1'b0);
      check_chars("hello", q8, 5, 64'h0000_006F_6C6C_6548);
      check("hello_count", bus.char_count, 5);
      check("hello_fetches", fetch_cnt, 2);
      check("hello_done_cnt", done_cnt, 1);
      check("hello_trunc", bus.truncated, 0);
      check("hello_idle", bus.busy, 0);

      // Unaligned start
      clear_mon();
      do_start(BASE + 32'd2);
      check("unal_fetch_addr", bus.mem_address, BASE);
      wait_done("unal", 1'b0);
      check_chars("unal", q8, 3, 64'h0000_0000_006F_6C6C);
      check("unal_count", bus.char_count, 3);
      check("unal_fetches", fetch_cnt, 2);

      // Empty string: done in cycle k+3
      mem_words[0] = 32'h0;
      clear_mon();
      do_start(BASE);
      check("empty_k1_rd", bus.mem_read, 1);
      @(negedge clk);
      check("empty_k2_valid", bus.char_valid, 0);
      check("empty_k2_done", bus.done, 0);
      @(negedge clk);
      check("empty_k3_done", bus.done, 1);
      @(negedge clk);
      check("empty_k4_done", bus.done, 0);
      check("empty_k4_busy", bus.busy, 0);
      check("empty_chars", q8.size(), 0);
      check("empty_count", bus.char_count, 0);
      mem_words[0] = 32'h6C6C_6548;

      // Backpressure on the first char, with a start pulse while busy
      clear_mon();
      bus.char_ready = 1'b0;
      do_start(BASE);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp_valid%0d", i), bus.char_valid, 1);
         check($sformatf("bp_data%0d", i), bus.char_data, 32'h48);
         check($sformatf("bp_rd%0d", i), bus.mem_read, 0);
         if (i == 0) begin bus.start = 1'b1; bus.str_addr = BASE + 32'd2; end
         @(negedge clk);
         bus.start = 1'b0;
      end
      check("bp_count_stall", bus.char_count, 0);
      bus.char_ready = 1'b1;
      wait_done("bp", 1'b0);
      check_chars("bp", q8, 5, 64'h0000_006F_6C6C_6548);
      check("bp_count", bus.char_count, 5);
      check("bp_fetches", fetch_cnt, 2);
      check("bp_done_cnt", done_cnt, 1);

      // Truncation at MAX_LEN=4: truncation wins over the next fetch
      clear_mon();
      do_start4(BASE);
      wait_done("trunc", 1'b1);
      check_chars("trunc", q4, 4, 64'h0000_0000_4443_4241);
      check("trunc_flag", bus4.truncated, 1);
      check("trunc_count", bus4.char_count, 4);
      check("trunc_fetches", fetch4_cnt, 1);
      repeat (2) @(negedge clk);
      check("trunc_held", bus4.truncated, 1);

      // Reset during EMIT aborts the request
      clear_mon();
      do_start(BASE);
      @(negedge clk);
      check("rstmid_in_emit", bus.char_valid, 1);
      reset = 1'b1;
      @(negedge clk);
      check("rstmid_busy", bus.busy, 0);
      check("rstmid_valid", bus.char_valid, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("rstmid_no_done", done_cnt, 0);
      check("rstmid_idle_valid", bus.char_valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
